// File: rtl/state_machine.sv
// state_machine: bit-serial adder controller.
// Two operands arrive LSB-first on A/B, one bit per clock, with the carry-in
// CIN taken in the start cycle. Each consumed bit produces one registered sum
// bit on S and its carry out on COUT. The running carry is held in the state
// encoding (ADD_C0 / ADD_C1), so there is no separate carry flop.
//
// Optional feature macro: STATEMACHINE_START_ABORT_EN
//   defined   -> start=1 in an ADD state abandons the current word and begins
//                a new one exactly as a start from IDLE would.
//   undefined -> start is ignored in ADD states and the word runs to DONE.
module state_machine #(
    parameter int WIDTH = 8
) (
    input  logic CLK,
    input  logic rst,
    input  logic NRST,
    input  logic start,
    input  logic CIN,
    input  logic A,
    input  logic B,
    output logic S,
    output logic COUT
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_WIDTH = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ADD_C0 = 2'b01,
        ADD_C1 = 2'b10,
        DONE   = 2'b11
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic           s_q, s_d;
    logic           cout_q, cout_d;

    // Full-adder results for the two ways a bit can be consumed: as bit 0 of
    // a fresh word (carry comes from CIN) or as a later bit (carry from state).
    logic cur_carry;
    logic load_sum, load_carry;
    logic add_sum, add_carry;
    logic abort_ok;

    // Datapath for both consume paths; the carry of a word in progress is
    // recovered from the state encoding.
    always_comb begin
        cur_carry  = (state_q == ADD_C1);
        load_sum   = A ^ B ^ CIN;
        load_carry = (A & B) | (A & CIN) | (B & CIN);
        add_sum    = A ^ B ^ cur_carry;
        add_carry  = (A & B) | (A & cur_carry) | (B & cur_carry);
`ifdef STATEMACHINE_START_ABORT_EN
        abort_ok   = start;
`else
        abort_ok   = 1'b0;
`endif
    end

    // Next-state and output logic; a stall (NRST low) keeps every default.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        s_d     = s_q;
        cout_d  = cout_q;

        if (NRST) begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        // The start cycle already consumes bit 0.
                        s_d     = load_sum;
                        cout_d  = load_carry;
                        count_d = CNT_ONE;
                        if (WIDTH == 1)
                            state_d = DONE;
                        else
                            state_d = load_carry ? ADD_C1 : ADD_C0;
                    end else begin
                        // DONE shows its result for one cycle only, then clears.
                        s_d     = 1'b0;
                        cout_d  = 1'b0;
                        state_d = IDLE;
                    end
                end

                ADD_C0, ADD_C1: begin
                    if (abort_ok) begin
                        // Restart: current bit becomes bit 0 of the new word.
                        s_d     = load_sum;
                        cout_d  = load_carry;
                        count_d = CNT_ONE;
                        if (WIDTH == 1)
                            state_d = DONE;
                        else
                            state_d = load_carry ? ADD_C1 : ADD_C0;
                    end else begin
                        s_d     = add_sum;
                        cout_d  = add_carry;
                        count_d = count_q + CNT_ONE;
                        if (count_d == CNT_WIDTH)
                            state_d = DONE;
                        else
                            state_d = add_carry ? ADD_C1 : ADD_C0;
                    end
                end

                default: begin
                    state_d = IDLE;
                    count_d = '0;
                    s_d     = 1'b0;
                    cout_d  = 1'b0;
                end
            endcase
        end
    end

    // State, counter and output registers; reset outranks the stall.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            s_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    assign S    = s_q;
    assign COUT = cout_q;

endmodule

// File: tb/tb_state_machine.sv
// Bench for state_machine: directed vector table (WIDTH=4) plus random
// stimulus, both checked against an arithmetic word-level model. A WIDTH=1
// instance shares the inputs to cover the single-bit word boundary.
module tb_state_machine;

    logic CLK = 1'b0;
    logic rst, NRST, start, CIN, A, B;
    logic s4, c4, s1, c1;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef STATEMACHINE_START_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    typedef struct packed {
        bit rst, nrst, start, cin, a, b;
        bit es, ec;
    } vec_t;

    state_machine #(.WIDTH(4)) u_dut (
        .CLK(CLK), .rst(rst), .NRST(NRST), .start(start), .CIN(CIN),
        .A(A), .B(B), .S(s4), .COUT(c4)
    );

    state_machine #(.WIDTH(1)) u_w1 (
        .CLK(CLK), .rst(rst), .NRST(NRST), .start(start), .CIN(CIN),
        .A(A), .B(B), .S(s1), .COUT(c1)
    );

    always #5 CLK = ~CLK;

    // Word-level model: operands are accumulated as integers and each output
    // bit is read from their arithmetic sum. Index 0 -> WIDTH 4, 1 -> WIDTH 1.
    int busy[2], nb[2], aacc[2], bacc[2], cinm[2];
    bit es[2], ec[2];

    task automatic calc(input int i);
        int sum;
        sum   = aacc[i] + bacc[i] + cinm[i];
        es[i] = sum[nb[i]-1];
        ec[i] = sum[nb[i]];
    endtask

    task automatic model_step(input int i, input int w, input vec_t v);
        if (v.rst) begin
            busy[i] = 0; nb[i] = 0; es[i] = 0; ec[i] = 0;
        end else if (!v.nrst) begin
            busy[i] = busy[i];
        end else if (v.start && (busy[i] == 0 || ABORT)) begin
            aacc[i] = int'(v.a); bacc[i] = int'(v.b); cinm[i] = int'(v.cin);
            nb[i] = 1;
            calc(i);
            busy[i] = (w > 1) ? 1 : 0;
        end else if (busy[i] != 0) begin
            aacc[i] = aacc[i] | (int'(v.a) << nb[i]);
            bacc[i] = bacc[i] | (int'(v.b) << nb[i]);
            nb[i]++;
            calc(i);
            if (nb[i] == w) busy[i] = 0;
        end else begin
            es[i] = 0; ec[i] = 0;
        end
    endtask

    task automatic check(input string name, input logic act, input bit exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(bit r, bit n, bit st, bit ci, bit a, bit b, bit e_s, bit e_c);
        vec_t v;
        v.rst = r; v.nrst = n; v.start = st; v.cin = ci; v.a = a; v.b = b;
        v.es = e_s; v.ec = e_c;
        return v;
    endfunction

    // Apply one cycle of inputs, then sample #1 after the edge.
    task automatic step(input vec_t v, input bit use_tbl, input string tag);
        rst = v.rst; NRST = v.nrst; start = v.start; CIN = v.cin; A = v.a; B = v.b;
        @(posedge CLK);
        #1;
        model_step(0, 4, v);
        model_step(1, 1, v);
        check({tag, "_m4_S"}, s4, es[0]);
        check({tag, "_m4_COUT"}, c4, ec[0]);
        check({tag, "_m1_S"}, s1, es[1]);
        check({tag, "_m1_COUT"}, c1, ec[1]);
        if (use_tbl) begin
            check({tag, "_tbl_S"}, s4, v.es);
            check({tag, "_tbl_COUT"}, c4, v.ec);
        end
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        rst = 1'b1; NRST = 1'b1; start = 1'b0; CIN = 1'b0; A = 1'b0; B = 1'b0;
        foreach (busy[i]) begin
            busy[i] = 0; nb[i] = 0; aacc[i] = 0; bacc[i] = 0; cinm[i] = 0;
            es[i] = 0; ec[i] = 0;
        end

        //              rst nrst st cin a  b  S  COUT
        // reset with busy-looking inputs, then a stalled start in IDLE
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0));
        // 5 + 3, CIN 0
        tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
        // 15 + 1 overflow, then back-to-back start in DONE: 0 + 0 + CIN 1
        tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
        // 5 + 3 with a 3-cycle stall after bit 1; stalled inputs are junk
        tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
        // reset mid-word discards the partial result; reset beats start
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 1, 1));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], 1'b1, $sformatf("tbl%0d", i));

        // start at bit 2 of 5+3 with CIN 1; outcome depends on abort build
        step(mk(0, 1, 1, 1, 1, 1, 0, 0), 1'b0, "abort_b0");
        step(mk(0, 1, 0, 0, 0, 1, 0, 0), 1'b0, "abort_b1");
        step(mk(0, 1, 1, 1, 1, 0, 0, 0), 1'b0, "abort_b2");
        for (int i = 0; i < 5; i++)
            step(mk(0, 1, 0, 0, 0, 0, 0, 0), 1'b0, $sformatf("abort_t%0d", i));

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            v = mk(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0),
                   ($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'b0, 1'b0);
            step(v, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
